// File: rtl/bank_cmd_arbiter.sv
// rtl/bank_cmd_arbiter.sv - per-bank command arbiter with tRRD/tCCD spacing and registered issue port
module bank_cmd_arbiter #(
    parameter int NUM_BANKS = 8,
    parameter int BA_BITS   = 3,
    parameter int T_RRD     = 4,
    parameter int T_CCD     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_BANKS-1:0]   req_valid_i,
    input  logic [2*NUM_BANKS-1:0] req_cmd_i,
    input  logic [5*NUM_BANKS-1:0] bank_cnt_i,
    input  logic [3*NUM_BANKS-1:0] bank_code_i,
    input  logic [NUM_BANKS-1:0]   bank_ras_ok_i,
    input  logic                   issue_ready_i,
    output logic                   issue_valid_o,
    output logic [BA_BITS-1:0]     issue_bank_o,
    output logic [1:0]             issue_cmd_o,
    output logic [NUM_BANKS-1:0]   grant_o
);

    localparam logic [1:0] CMD_ACT = 2'b00;
    localparam logic [1:0] CMD_RD  = 2'b01;
    localparam logic [1:0] CMD_WR  = 2'b10;
    localparam logic [1:0] CMD_PRE = 2'b11;

    // Spacing counters only need to hold T-1.
    localparam int RRD_W = (T_RRD > 1) ? $clog2(T_RRD) : 1;
    localparam int CCD_W = (T_CCD > 1) ? $clog2(T_CCD) : 1;
    localparam logic [RRD_W-1:0] RRD_RELOAD = RRD_W'(T_RRD - 1);
    localparam logic [CCD_W-1:0] CCD_RELOAD = CCD_W'(T_CCD - 1);
    localparam logic [BA_BITS:0]   NB_EXT    = (BA_BITS + 1)'(NUM_BANKS);
    localparam logic [BA_BITS-1:0] LAST_BANK = BA_BITS'(NUM_BANKS - 1);

    logic                 issue_valid_q, issue_valid_d;
    logic [BA_BITS-1:0]   issue_bank_q, issue_bank_d;
    logic [1:0]           issue_cmd_q, issue_cmd_d;
    logic [BA_BITS-1:0]   rr_ptr_q, rr_ptr_d;
    logic [RRD_W-1:0]     rrd_cnt_q, rrd_cnt_d;
    logic [CCD_W-1:0]     ccd_cnt_q, ccd_cnt_d;
    // Two-stage mask: stage a covers the first cycle after accept, stage b the second.
    logic [NUM_BANKS-1:0] mask_a_q, mask_a_d;
    logic [NUM_BANKS-1:0] mask_b_q, mask_b_d;

    logic [NUM_BANKS-1:0] elig_col, elig_pre, elig_act, cand;
    logic [BA_BITS:0]     scan_sum;
    logic [BA_BITS-1:0]   win_bank;
    logic                 win_found;
    logic                 accept;

    assign accept = issue_valid_q && issue_ready_i;

    // Per-bank legality: latency expired, not masked, and command allowed after the last one.
    always_comb begin
        elig_col = '0;
        elig_pre = '0;
        elig_act = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (req_valid_i[i] && !(mask_a_q[i] || mask_b_q[i]) &&
                (bank_cnt_i[5*i +: 5] == 5'd0)) begin
                unique case (req_cmd_i[2*i +: 2])
                    CMD_ACT: elig_act[i] = ((bank_code_i[3*i +: 3] == 3'd0) ||
                                            (bank_code_i[3*i +: 3] == 3'd2)) &&
                                           (rrd_cnt_q == '0);
                    CMD_RD, CMD_WR:
                             elig_col[i] = ((bank_code_i[3*i +: 3] == 3'd1) ||
                                            (bank_code_i[3*i +: 3] == 3'd3) ||
                                            (bank_code_i[3*i +: 3] == 3'd4)) &&
                                           (ccd_cnt_q == '0);
                    CMD_PRE: elig_pre[i] = ((bank_code_i[3*i +: 3] == 3'd1) ||
                                            (bank_code_i[3*i +: 3] == 3'd3) ||
                                            (bank_code_i[3*i +: 3] == 3'd4)) &&
                                           bank_ras_ok_i[i];
                    default: ;
                endcase
            end
        end
    end

    // Column commands beat precharges beat activates; round-robin from rr_ptr within the class.
    always_comb begin
        if (elig_col != '0) begin
            cand = elig_col;
        end else if (elig_pre != '0) begin
            cand = elig_pre;
        end else begin
            cand = elig_act;
        end
        win_found = 1'b0;
        win_bank  = '0;
        scan_sum  = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            scan_sum = {1'b0, rr_ptr_q} + (BA_BITS + 1)'(k);
            if (scan_sum >= NB_EXT) begin
                scan_sum = scan_sum - NB_EXT;
            end
            if (!win_found && cand[scan_sum[BA_BITS-1:0]]) begin
                win_found = 1'b1;
                win_bank  = scan_sum[BA_BITS-1:0];
            end
        end
    end

    // Next state: accept retires the command and arms spacing/masks; otherwise an empty port loads.
    always_comb begin
        issue_valid_d = issue_valid_q;
        issue_bank_d  = issue_bank_q;
        issue_cmd_d   = issue_cmd_q;
        rr_ptr_d      = rr_ptr_q;
        rrd_cnt_d     = (rrd_cnt_q == '0) ? '0 : rrd_cnt_q - RRD_W'(1);
        ccd_cnt_d     = (ccd_cnt_q == '0) ? '0 : ccd_cnt_q - CCD_W'(1);
        mask_a_d      = '0;
        mask_b_d      = mask_a_q;
        if (accept) begin
            issue_valid_d = 1'b0;
            rr_ptr_d      = (issue_bank_q == LAST_BANK) ? '0 : issue_bank_q + BA_BITS'(1);
            mask_a_d      = grant_o;
            if (issue_cmd_q == CMD_ACT) begin
                rrd_cnt_d = RRD_RELOAD;
            end
            if ((issue_cmd_q == CMD_RD) || (issue_cmd_q == CMD_WR)) begin
                ccd_cnt_d = CCD_RELOAD;
            end
        end else if (!issue_valid_q && win_found) begin
            issue_valid_d = 1'b1;
            issue_bank_d  = win_bank;
            issue_cmd_d   = req_cmd_i[{win_bank, 1'b0} +: 2];
        end
    end

    // Grant is the only combinational output: one-hot of the bank being accepted this cycle.
    always_comb begin
        grant_o = '0;
        if (accept) begin
            grant_o[issue_bank_q] = 1'b1;
        end
    end

    // State registers; reset drops any pending command immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_valid_q <= 1'b0;
            issue_bank_q  <= '0;
            issue_cmd_q   <= CMD_ACT;
            rr_ptr_q      <= '0;
            rrd_cnt_q     <= '0;
            ccd_cnt_q     <= '0;
            mask_a_q      <= '0;
            mask_b_q      <= '0;
        end else begin
            issue_valid_q <= issue_valid_d;
            issue_bank_q  <= issue_bank_d;
            issue_cmd_q   <= issue_cmd_d;
            rr_ptr_q      <= rr_ptr_d;
            rrd_cnt_q     <= rrd_cnt_d;
            ccd_cnt_q     <= ccd_cnt_d;
            mask_a_q      <= mask_a_d;
            mask_b_q      <= mask_b_d;
        end
    end

    assign issue_valid_o = issue_valid_q;
    assign issue_bank_o  = issue_bank_q;
    assign issue_cmd_o   = issue_cmd_q;

endmodule
